// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Opcodes, control-word typedefs and decode helpers shared by the
//            ID stage and its register file.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
  } m_ctrl_t;

  typedef struct packed {
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
  } ex_ctrl_t;

  typedef struct packed {
    wb_ctrl_t wb;
    m_ctrl_t  m;
    ex_ctrl_t ex;
  } id_ctrl_t;

  localparam wb_ctrl_t WB_NOP   = '0;
  localparam m_ctrl_t  M_NOP    = '0;
  localparam ex_ctrl_t EX_NOP   = '0;
  localparam id_ctrl_t CTRL_NOP = '{wb: WB_NOP, m: M_NOP, ex: EX_NOP};

  // Main control table; unknown opcodes decode to a NOP.
  function automatic id_ctrl_t decode_ctrl(input logic [5:0] opcode);
    id_ctrl_t c;
    c = CTRL_NOP;
    case (opcode)
      OP_RTYPE: c = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
      OP_LW:    c = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
      OP_SW:    c = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
      OP_BEQ:   c = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
      OP_ADDI:  c = '{wb: 2'b10, m: 3'b000, ex: 4'b0001};
      default:  c = CTRL_NOP;
    endcase
    return c;
  endfunction

  // Instructions whose rt field is a source operand.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_regfile.sv
`default_nettype none
// ============================================================================
// Module   : id_regfile
// Brief    : 32 x XLEN register file, two combinational read ports, one
//            write port, r0 hard-wired to zero, optional write-through.
// Revision : 1.0 - initial release
// ============================================================================
module id_regfile
  import mips_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr_a_i,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] mem_q [32];

  // Storage: cleared on reset, r0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (BYPASS != 0) begin : g_bypass
    logic w_wr_active;
    assign w_wr_active = we_i && (waddr_i != 5'd0);
    // A read of the register being written this cycle sees the new data.
    assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 :
                       (w_wr_active && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 :
                       (w_wr_active && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
  end else begin : g_no_bypass
    assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : mem_q[raddr_b_i];
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_hz.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_hz
// Brief    : MIPS decode stage: control decode, register-file access, sign
//            extension, load-use hazard detection, flush, ID/EX register.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_hz
  import mips_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BYPASS    = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] npc,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_writereg,
  input  logic [XLEN-1:0] wb_writedata,
  input  logic            flush,
  output logic            stall,
  output logic            ex_valid,
  output logic [1:0]      wb_out,
  output logic [2:0]      m_out,
  output logic [3:0]      ex_out,
  output logic [XLEN-1:0] npc_out,
  output logic [XLEN-1:0] reg_rs_out,
  output logic [XLEN-1:0] reg_rt_out,
  output logic [XLEN-1:0] sign_ext_out,
  output logic [4:0]      rs_out,
  output logic [4:0]      rt_out,
  output logic [4:0]      rd_out
);

  logic [5:0]      w_opcode;
  id_ctrl_t        w_ctrl;
  logic            w_uses_rt;
  logic            w_hazard;
  logic            w_bubble;
  logic [XLEN-1:0] w_rs_data;
  logic [XLEN-1:0] w_rt_data;
  logic [XLEN-1:0] w_sext;

  logic            ex_valid_d, ex_valid_q;
  id_ctrl_t        ctrl_d,     ctrl_q;
  logic [XLEN-1:0] npc_d,      npc_q;
  logic [XLEN-1:0] rs_val_d,   rs_val_q;
  logic [XLEN-1:0] rt_val_d,   rt_val_q;
  logic [XLEN-1:0] sext_d,     sext_q;
  logic [4:0]      rs_d,       rs_q;
  logic [4:0]      rt_d,       rt_q;
  logic [4:0]      rd_d,       rd_q;

  id_regfile #(
    .XLEN   (XLEN),
    .BYPASS (BYPASS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wb_regwrite),
    .waddr_i   (wb_writereg),
    .wdata_i   (wb_writedata),
    .raddr_a_i (instr[25:21]),
    .raddr_b_i (instr[20:16]),
    .rdata_a_o (w_rs_data),
    .rdata_b_o (w_rt_data)
  );

  assign w_opcode  = instr[31:26];
  assign w_uses_rt = uses_rt(w_opcode);
  assign w_sext    = {{(XLEN-16){instr[15]}}, instr[15:0]};

  // Control decode of the instruction sitting in IF/ID.
  always_comb begin
    w_ctrl = decode_ctrl(w_opcode);
  end

  // Load-use hazard: a valid load in ID/EX targets a source of the ID instruction.
  always_comb begin
    w_hazard = ex_valid_q && ctrl_q.m.memread && (rt_q != 5'd0) &&
               ((rt_q == instr[25:21]) || (w_uses_rt && (rt_q == instr[20:16])));
    stall    = (HAZARD_EN != 0) && if_valid && w_hazard;
  end

  // ID/EX next state: flush, stall and an empty IF/ID all insert a bubble;
  // the datapath fields load regardless so their contents stay deterministic.
  always_comb begin
    w_bubble   = flush || stall || !if_valid;
    ex_valid_d = !w_bubble;
    ctrl_d     = w_bubble ? CTRL_NOP : w_ctrl;
    npc_d      = npc;
    rs_val_d   = w_rs_data;
    rt_val_d   = w_rt_data;
    sext_d     = w_sext;
    rs_d       = instr[25:21];
    rt_d       = instr[20:16];
    rd_d       = instr[15:11];
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= CTRL_NOP;
      npc_q      <= '0;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      sext_q     <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ctrl_q     <= ctrl_d;
      npc_q      <= npc_d;
      rs_val_q   <= rs_val_d;
      rt_val_q   <= rt_val_d;
      sext_q     <= sext_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign wb_out       = ctrl_q.wb;
  assign m_out        = ctrl_q.m;
  assign ex_out       = ctrl_q.ex;
  assign npc_out      = npc_q;
  assign reg_rs_out   = rs_val_q;
  assign reg_rt_out   = rt_val_q;
  assign sign_ext_out = sext_q;
  assign rs_out       = rs_q;
  assign rt_out       = rt_q;
  assign rd_out       = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_hz.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_hz
// Brief    : Scoreboard bench for id_stage_hz with directed vectors; side
//            instances cover BYPASS=0 and HAZARD_EN=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage_hz;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        wb_regwrite;
  logic [4:0]  wb_writereg;
  logic [31:0] wb_writedata;
  logic        flush;

  logic        stall, ex_valid;
  logic [1:0]  wb_out;
  logic [2:0]  m_out;
  logic [3:0]  ex_out;
  logic [31:0] npc_out, reg_rs_out, reg_rt_out, sign_ext_out;
  logic [4:0]  rs_out, rt_out, rd_out;

  logic        nb_stall, nb_ex_valid;
  logic [1:0]  nb_wb;
  logic [2:0]  nb_m;
  logic [3:0]  nb_ex;
  logic [31:0] nb_npc, nb_rs_val, nb_rt_val, nb_sext;
  logic [4:0]  nb_rs, nb_rt, nb_rd;

  logic        nh_stall, nh_ex_valid;
  logic [1:0]  nh_wb;
  logic [2:0]  nh_m;
  logic [3:0]  nh_ex;
  logic [31:0] nh_npc, nh_rs_val, nh_rt_val, nh_sext;
  logic [4:0]  nh_rs, nh_rt, nh_rd;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    bit          chk_data;
    logic        v;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc, rsv, rtv, sx;
    logic [4:0]  rs, rt, rd;
  } exp_t;

  exp_t sb[$];

  id_stage_hz #(.XLEN(32), .BYPASS(1), .HAZARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr), .npc(npc),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .wb_out(wb_out), .m_out(m_out),
    .ex_out(ex_out), .npc_out(npc_out), .reg_rs_out(reg_rs_out), .reg_rt_out(reg_rt_out),
    .sign_ext_out(sign_ext_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out));

  id_stage_hz #(.XLEN(32), .BYPASS(0), .HAZARD_EN(1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr), .npc(npc),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
    .flush(flush), .stall(nb_stall), .ex_valid(nb_ex_valid), .wb_out(nb_wb), .m_out(nb_m),
    .ex_out(nb_ex), .npc_out(nb_npc), .reg_rs_out(nb_rs_val), .reg_rt_out(nb_rt_val),
    .sign_ext_out(nb_sext), .rs_out(nb_rs), .rt_out(nb_rt), .rd_out(nb_rd));

  id_stage_hz #(.XLEN(32), .BYPASS(1), .HAZARD_EN(0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr), .npc(npc),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
    .flush(flush), .stall(nh_stall), .ex_valid(nh_ex_valid), .wb_out(nh_wb), .m_out(nh_m),
    .ex_out(nh_ex), .npc_out(nh_npc), .reg_rs_out(nh_rs_val), .reg_rt_out(nh_rt_val),
    .sign_ext_out(nh_sext), .rs_out(nh_rs), .rt_out(nh_rt), .rd_out(nh_rd));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input string nm, input logic [1:0] wb, input logic [2:0] m,
                              input logic [3:0] ex, input logic [31:0] pc,
                              input logic [31:0] rsv, input logic [31:0] rtv,
                              input logic [31:0] sx, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd);
    exp_t e;
    e.name = nm; e.chk_data = 1'b1; e.v = 1'b1;
    e.wb = wb; e.m = m; e.ex = ex; e.npc = pc; e.rsv = rsv; e.rtv = rtv; e.sx = sx;
    e.rs = rs; e.rt = rt; e.rd = rd;
    return e;
  endfunction

  function automatic exp_t bub(input string nm);
    exp_t e;
    e.name = nm; e.chk_data = 1'b0; e.v = 1'b0;
    e.wb = '0; e.m = '0; e.ex = '0; e.npc = '0; e.rsv = '0; e.rtv = '0; e.sx = '0;
    e.rs = '0; e.rt = '0; e.rd = '0;
    return e;
  endfunction

  // Drive one ID cycle on the falling edge, check stall, queue the ID/EX expectation.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic exp_stall, input exp_t e);
    @(negedge clk);
    if_valid = iv; instr = ins; npc = pc; flush = fl;
    wb_regwrite = we; wb_writereg = wr; wb_writedata = wd;
    #1;
    chk({e.name, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
    sb.push_back(e);
  endtask

  // Monitor: compare the ID/EX register one step after each edge with a pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, e.v});
        chk({e.name, ".wb_out"},   {30'd0, wb_out},   {30'd0, e.wb});
        chk({e.name, ".m_out"},    {29'd0, m_out},    {29'd0, e.m});
        chk({e.name, ".ex_out"},   {28'd0, ex_out},   {28'd0, e.ex});
        if (e.chk_data) begin
          chk({e.name, ".npc_out"},      npc_out,      e.npc);
          chk({e.name, ".reg_rs_out"},   reg_rs_out,   e.rsv);
          chk({e.name, ".reg_rt_out"},   reg_rt_out,   e.rtv);
          chk({e.name, ".sign_ext_out"}, sign_ext_out, e.sx);
          chk({e.name, ".rs_out"}, {27'd0, rs_out}, {27'd0, e.rs});
          chk({e.name, ".rt_out"}, {27'd0, rt_out}, {27'd0, e.rt});
          chk({e.name, ".rd_out"}, {27'd0, rd_out}, {27'd0, e.rd});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; instr = '0; npc = '0; flush = 1'b0;
    wb_regwrite = 1'b0; wb_writereg = '0; wb_writedata = '0;
    #3;
    chk("reset.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset.stall",    {31'd0, stall},    32'd0);
    chk("reset.ctrl",     {23'd0, wb_out, m_out, ex_out}, 32'd0);
    chk("reset.npc_out",  npc_out, 32'd0);
    chk("reset.sign_ext", sign_ext_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Register writes through WB while IF/ID is empty.
    step(0, 32'h0, 32'h0, 0, 1, 5'd5, 32'h0000_1234, 0, bub("wr_r5"));
    step(0, 32'h0, 32'h0, 0, 1, 5'd6, 32'h0000_0010, 0, bub("wr_r6"));
    // R-type add rd=7, rs=5, rt=6.
    step(1, rtype(5, 6, 7), 32'h100, 0, 0, 0, 0, 0,
         mk("add", 2'b10, 3'b000, 4'b1100, 32'h100, 32'h1234, 32'h10, 32'h3820, 5, 6, 7));
    // lw r8 then dependent add: one stall cycle, one bubble, then the add.
    step(1, itype(6'h23, 0, 8, 16'hFFFC), 32'h104, 0, 0, 0, 0, 0,
         mk("lw_r8", 2'b11, 3'b010, 4'b0001, 32'h104, 0, 0, 32'hFFFF_FFFC, 0, 8, 31));
    step(1, rtype(8, 6, 9), 32'h108, 0, 0, 0, 0, 1, bub("use_stall"));
    chk("nohaz.stall", {31'd0, nh_stall}, 32'd0);
    step(1, rtype(8, 6, 9), 32'h108, 0, 0, 0, 0, 0,
         mk("use_load", 2'b10, 3'b000, 4'b1100, 32'h108, 0, 32'h10, 32'h4820, 8, 6, 9));
    // lw r0 followed by a use of r0: no hazard.
    step(1, itype(6'h23, 0, 0, 16'h0004), 32'h10C, 0, 0, 0, 0, 0,
         mk("lw_r0", 2'b11, 3'b010, 4'b0001, 32'h10C, 0, 0, 32'h4, 0, 0, 0));
    step(1, rtype(0, 0, 1), 32'h110, 0, 0, 0, 0, 0,
         mk("use_r0", 2'b10, 3'b000, 4'b1100, 32'h110, 0, 0, 32'h0820, 0, 0, 1));
    // Same-cycle write of r9 while addi reads rs=9.
    step(1, itype(6'h08, 9, 10, 16'h0001), 32'h114, 0, 1, 5'd9, 32'hDEAD_BEEF, 0,
         mk("bypass", 2'b10, 3'b000, 4'b0001, 32'h114, 32'hDEAD_BEEF, 0, 32'h1, 9, 10, 0));
    @(posedge clk); #2;
    chk("nobypass.reg_rs_out", nb_rs_val, 32'h0);
    // Write attempt to r0 while reading r0 and r9.
    step(1, rtype(0, 9, 2), 32'h118, 0, 1, 5'd0, 32'hFFFF_FFFF, 0,
         mk("wr_r0", 2'b10, 3'b000, 4'b1100, 32'h118, 0, 32'hDEAD_BEEF, 32'h1020, 0, 9, 2));
    // Load then a flush coinciding with the stall it causes.
    step(1, itype(6'h23, 0, 11, 16'h0000), 32'h11C, 0, 0, 0, 0, 0,
         mk("lw_r11", 2'b11, 3'b010, 4'b0001, 32'h11C, 0, 0, 32'h0, 0, 11, 0));
    step(1, rtype(11, 0, 3), 32'h120, 1, 0, 0, 0, 1, bub("flush_stall"));
    // Unknown opcode with a negative immediate.
    step(1, {6'h3F, 5'd1, 5'd2, 16'h8000}, 32'h124, 0, 0, 0, 0, 0,
         mk("op3f", 2'b00, 3'b000, 4'b0000, 32'h124, 0, 0, 32'hFFFF_8000, 1, 2, 16));
    step(1, itype(6'h04, 5, 6, 16'h0003), 32'h128, 0, 0, 0, 0, 0,
         mk("beq", 2'b00, 3'b100, 4'b0010, 32'h128, 32'h1234, 32'h10, 32'h3, 5, 6, 0));
    step(1, itype(6'h2B, 5, 6, 16'h0010), 32'h12C, 0, 0, 0, 0, 0,
         mk("sw", 2'b00, 3'b001, 4'b0001, 32'h12C, 32'h1234, 32'h10, 32'h10, 5, 6, 0));

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    if_valid = 1'b1; instr = itype(6'h08, 5, 6, 16'h0007); npc = 32'h130;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("areset.ctrl",     {23'd0, wb_out, m_out, ex_out}, 32'd0);
    chk("areset.npc_out",  npc_out, 32'd0);
    chk("areset.reg_rs",   reg_rs_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, rtype(5, 6, 7), 32'h134, 0, 0, 0, 0, 0,
         mk("post_reset", 2'b10, 3'b000, 4'b1100, 32'h134, 0, 0, 32'h3820, 5, 6, 7));

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #3;
    chk("scoreboard.drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage_hz.md
# id_stage_hz

Parametrised successor to the MIPS decode stage. It takes the IF/ID instruction and next PC, decodes control, reads and writes the register file, and sign-extends the immediate. It also detects load-use hazards, accepts a flush from branch resolution, and registers everything into an ID/EX register that carries a valid bit. It sits between the IF/ID register and the execute stage; the WB stage drives its register-file write port.

## Interface
Parameters:
- XLEN, 32: datapath width; must be ≥ 32.
- BYPASS, 1: 1 makes the register file write-through, so a read of the register written this cycle returns the write data.
- HAZARD_EN, 1: 0 ties `stall` to 0 (the compiler schedules the delay slots).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- if_valid  in  1  IF/ID holds a real instruction.
- instr  in  32  IF/ID instruction.
- npc  in  XLEN  IF/ID PC+4.
- wb_regwrite  in  1  WB write enable.
- wb_writereg  in  5  WB destination register.
- wb_writedata  in  XLEN  WB write data.
- flush  in  1  squash the instruction currently in ID.
- stall  out  1  load-use stall; IF and IF/ID must hold.
- ex_valid  out  1  ID/EX holds a real instruction.
- wb_out  out  2  {RegWrite, MemtoReg}.
- m_out  out  3  {Branch, MemRead, MemWrite}.
- ex_out  out  4  {RegDst, ALUOp[1:0], ALUSrc}.
- npc_out, reg_rs_out, reg_rt_out, sign_ext_out  out  XLEN  registered datapath values.
- rs_out, rt_out, rd_out  out  5  registered instr[25:21], [20:16], [15:11].

## Operation
Control decode uses opcode = instr[31:26]; wb/m/ex are listed in that order:
- 0x00 R-type: 10 / 000 / 1100.
- 0x23 lw: 11 / 010 / 0001.
- 0x2B sw: 00 / 001 / 0001.
- 0x04 beq: 00 / 100 / 0010.
- 0x08 addi: 10 / 000 / 0001.
- Any other opcode: all zeros (NOP).

Register file:
- 32 × XLEN.
- r0 reads 0 and is never written.
- A write occurs on the clock edge when wb_regwrite=1 and wb_writereg≠0.
- Asynchronous reset clears all entries.
- Reads are combinational. With BYPASS=1, when a write is in progress to a register, a read of that same register returns wb_writedata.

Sign extension: sign_ext_out = {(XLEN−16) copies of instr[15], instr[15:0]}.

Hazard detection (combinational):
- `uses_rt` is true for R-type, sw and beq.
- stall = HAZARD_EN & if_valid & ex_valid & m_out[1] & rt_out≠0 & (rt_out==instr[25:21] | (uses_rt & rt_out==instr[20:16])).

ID/EX update, evaluated on every clock edge in this priority order:
- flush=1: bubble; flush wins over stall.
- stall=1: bubble.
- if_valid=0: bubble.
- Otherwise load the decoded instruction and set ex_valid=1.

A bubble means:
- ex_valid=0 and wb_out, m_out, ex_out all set to 0.
- Datapath fields still load the current values; they are don't-care, but must be deterministic.

## Timing
- Reset: every output register is 0, including ex_valid=0. stall evaluates to 0 because ex_valid=0.
- Decode-to-ID/EX latency is one cycle.
- A stall lasts exactly one cycle: the next edge loads a bubble, so ex_valid=0 and the hazard term clears.
- A register-file write and an ID/EX load on the same edge: with BYPASS=1, ID/EX captures the new value; with BYPASS=0, it captures the old value.
- Reset deasserted mid-stream: the first edge after deassertion behaves as a normal edge. If rst_n is asserted, the in-flight instruction is lost.
- stall and flush in the same cycle: the bubble is inserted and stall remains visible to IF. IF gives flush priority.

## Structure
- Package `mips_pkg` holds:
  - the opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - the packed typedefs wb_ctrl_t, m_ctrl_t, ex_ctrl_t;
  - the localparam NOP control values.
- One sub-module, `id_regfile` (XLEN, BYPASS): the register file with its asynchronous reset and write-through option.
- Control decode, hazard logic and the ID/EX register stay in the top module.

## Test plan
- Reset, then write r5=0x0000_1234 and r6=0x0000_0010 via WB. Feed R-type add rd=7, rs=5, rt=6. Next cycle: wb_out=10, ex_out=1100, reg_rs_out=0x1234, reg_rt_out=0x10, rd_out=7, ex_valid=1.
- lw r8 (opcode 0x23, rt=8, imm=0xFFFC) followed by add rs=8. While the add is in ID: stall=1 for exactly one cycle, then the bubble appears (ex_valid=0, controls 0). Next edge: the add is loaded with ex_valid=1.
- lw r0 followed by a use of r0: stall stays 0. Repeat with HAZARD_EN=0 and the lw r8 case: stall stays 0.
- Same-cycle WB write r9=0xDEAD_BEEF while ID reads rs=9. With BYPASS=1, reg_rs_out=0xDEAD_BEEF; with BYPASS=0, it is the prior value. A write to r0 leaves r0 reading 0.
- Assert flush together with a stall-causing instruction: the bubble is loaded. Drive unknown opcode 0x3F: all controls are 0 and ex_valid=1. Check imm=0x8000 gives sign_ext_out=0xFFFF_8000.
- Assert rst_n low asynchronously mid-stream: ex_valid and all outputs go to 0 immediately. The register file reads 0 after release.
